period_bus_sampler_mc: RTL

//  Multi-channel successor to the single-channel periodic bus sync.

---
 rtl/period_bus_sampler_mc_if.sv | 29 ++
 rtl/period_bus_sampler_mc.sv | 112 +++++++++++
 2 files changed

// File: rtl/period_bus_sampler_mc_if.sv
// Bundle of the control inputs, packed channel buses and status outputs of period_bus_sampler_mc.
// Channel c occupies bits [c*BUS_SIZE +: BUS_SIZE] of the data vectors.
interface period_bus_sampler_mc_if #(
    parameter int BUS_SIZE  = 8,
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int STABLE_W  = 3
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         i_enable;
    logic [CNT_WIDTH-1:0]         i_period;
    logic [STABLE_W-1:0]          i_stable_len;
    logic                         i_force;
    logic [NUM_CH*BUS_SIZE-1:0]   i_in_data;
    logic [NUM_CH*BUS_SIZE-1:0]   o_out_data;
    logic [NUM_CH-1:0]            o_out_chg;
    logic [CH_W-1:0]              o_cur_ch;

    modport master (
        output i_enable, i_period, i_stable_len, i_force, i_in_data,
        input  o_out_data, o_out_chg, o_cur_ch
    );

    modport slave (
        input  i_enable, i_period, i_stable_len, i_force, i_in_data,
        output o_out_data, o_out_chg, o_cur_ch
    );
endinterface

// File: rtl/period_bus_sampler_mc.sv
// Round-robin periodic sampler for NUM_CH quasi-static status buses with per-channel
// deglitching (stable_len equal samples before commit) and one-cycle change pulses.
module period_bus_sampler_mc #(
    parameter int BUS_SIZE  = 8,
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int STABLE_W  = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    period_bus_sampler_mc_if.slave bus
);
    localparam int                  CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [STABLE_W-1:0] SCNT_MAX = '1;
    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);

    function automatic logic [STABLE_W-1:0] sat_inc(input logic [STABLE_W-1:0] v);
        return (v == SCNT_MAX) ? SCNT_MAX : v + STABLE_W'(1);
    endfunction

    logic [NUM_CH-1:0][BUS_SIZE-1:0] w_in;
    logic                            w_tick;
    logic [CNT_WIDTH-1:0]            r_period_cnt;
    logic [CH_W-1:0]                 r_cur_ch;

    logic [BUS_SIZE-1:0]             r_samp_p1;
    logic [CH_W-1:0]                 r_samp_ch_p1;
    logic                            r_vld_p1;

    logic [NUM_CH-1:0][BUS_SIZE-1:0] r_cand;
    logic [NUM_CH-1:0][BUS_SIZE-1:0] r_out;
    logic [NUM_CH-1:0][STABLE_W-1:0] r_scnt;
    logic [NUM_CH-1:0]               r_chg;
    logic [NUM_CH-1:0]               w_chg_force;
    logic [STABLE_W-1:0]             w_len;
    logic [STABLE_W-1:0]             w_scnt_nxt;
    logic                            w_commit;

    assign w_in   = bus.i_in_data;
    // ">=" lets a period shrunk below the running count tick on the very next cycle.
    assign w_tick = bus.i_enable && !bus.i_force && (r_period_cnt >= bus.i_period);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_cnt <= '0;
            r_cur_ch     <= '0;
        end else if (bus.i_force) begin
            r_period_cnt <= '0;
            r_cur_ch     <= '0;
        end else if (bus.i_enable) begin
            if (w_tick) begin
                r_period_cnt <= '0;
                r_cur_ch     <= (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + CH_W'(1);
            end else begin
                r_period_cnt <= r_period_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // ---- stage 1: capture the selected channel on the tick edge ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_vld_p1 <= 1'b0;
        else          r_vld_p1 <= w_tick;
    end

    always_ff @(posedge clk) begin
        if (w_tick) begin
            r_samp_p1    <= w_in[r_cur_ch];
            r_samp_ch_p1 <= r_cur_ch;
        end
    end

    // ---- stage 2: stability count, commit and change detect ----
    always_comb begin
        w_len       = (bus.i_stable_len == '0) ? STABLE_W'(1) : bus.i_stable_len;
        w_scnt_nxt  = (r_samp_p1 != r_cand[r_samp_ch_p1]) ? STABLE_W'(1)
                                                          : sat_inc(r_scnt[r_samp_ch_p1]);
        w_commit    = (w_scnt_nxt >= w_len);
        w_chg_force = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_chg_force[c] = (w_in[c] != r_out[c]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand <= '0;
            r_scnt <= '0;
            r_out  <= '0;
            r_chg  <= '0;
        end else begin
            r_chg <= '0;
            if (bus.i_force) begin
                r_cand <= w_in;
                r_out  <= w_in;
                r_scnt <= {NUM_CH{SCNT_MAX}};
                r_chg  <= w_chg_force;
            end else if (r_vld_p1) begin
                r_cand[r_samp_ch_p1] <= r_samp_p1;
                r_scnt[r_samp_ch_p1] <= w_scnt_nxt;
                if (w_commit) begin
                    r_out[r_samp_ch_p1] <= r_samp_p1;
                    r_chg[r_samp_ch_p1] <= (r_samp_p1 != r_out[r_samp_ch_p1]);
                end
            end
        end
    end

    assign bus.o_out_data = r_out;
    assign bus.o_out_chg  = r_chg;
    assign bus.o_cur_ch   = r_cur_ch;
endmodule
